sd_request_arbiter: RTL and testbench
=====================================

# sd_request_arbiter

Shares the single SD-card sector controller between up to N independent requesters (c1541 drive, image loader targets, save/writeback paths). Each requester presents the same rd/wr/lba/busy/done handshake it would present to the SD controller directly; the arbiter grants one transaction at a time round-robin, forwards that requester's LBA and command, and routes busy, done and byte strobes back only to the owner. It also runs a watchdog that aborts a command the SD controller never accepts.

## Interface
- N, 6: number of requesters (2..8)
- TIMEOUT, 1000000: cycles allowed in ISSUE for sd_busy to rise before abort (≥2, fits 24 bits)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req_lba  in  32*N  per-requester sector address, requester i at [32*i+31:32*i]
- req_rd  in  N  read request, level, held until req_busy[i] seen
- req_wr  in  N  write request, level, held until req_busy[i] seen
- req_busy  out  N  sd_busy routed to current owner
- req_done  out  N  sd_done routed to current owner
- req_strobe  out  N  sd_rd_byte_strobe routed to current owner
- req_err  out  N  one-cycle pulse: owner's command timed out
- sd_lba  out  32  latched LBA of granted transaction
- sd_rd  out  1  read command to SD controller
- sd_wr  out  1  write command to SD controller
- sd_busy  in  1  SD controller accepted/working
- sd_done  in  1  SD controller finished sector
- sd_rd_byte_strobe  in  1  SD byte strobe
- grant_id  out  3  index of current/last owner
- active  out  1  high in ISSUE and WAIT_DONE

## Operation
- States: IDLE, ISSUE, WAIT_DONE, RELEASE.
- IDLE: pending = req_rd | req_wr. If any pending, pick first pending index scanning last_grant+1, last_grant+2, … mod N. Latch grant_id, sd_lba ← req_lba[g], dir ← read if req_rd[g] else write (read wins when both set). Assert sd_rd or sd_wr; clear watchdog; go ISSUE.
- ISSUE: hold sd_rd/sd_wr. When sd_busy=1: drop sd_rd/sd_wr, go WAIT_DONE. Else watchdog increments; at TIMEOUT−1: drop command, pulse req_err[g], go RELEASE. sd_done ignored in ISSUE.
- WAIT_DONE: on sd_done go RELEASE.
- RELEASE: last_grant ← grant_id; go IDLE. One cycle; lets owner drop its request before re-arbitration.
- Routing (combinational, same cycle): req_busy[i] = sd_busy & active & (grant_id==i); req_done[i] = sd_done & state==WAIT_DONE & (grant_id==i); req_strobe[i] = sd_rd_byte_strobe & active & (grant_id==i). Non-owners see 0.
- A requester still asserting in RELEASE is treated as a fresh request; round-robin places it after all other pending requesters.
- Unused indices ≥N never granted.

## Timing
- Reset values: state IDLE, sd_rd=0, sd_wr=0, sd_lba=0, grant_id=0, last_grant=N−1 (requester 0 highest priority first), req_err=0, watchdog=0; routed outputs 0 because active=0.
- Reset mid-transaction: command and ownership dropped at that edge; any later sd_done/strobe ignored until a new grant.
- sd_rd/sd_wr/sd_lba/grant_id registered: request sampled in IDLE at edge k → command visible after edge k.
- Command deasserts on the edge sampling sd_busy=1.
- Abort: with sd_busy held 0, command visible for exactly TIMEOUT cycles; req_err pulse in the cycle after.
- Minimum back-to-back gap: done edge → RELEASE → IDLE → next command visible 3 edges after sd_done sampled.
- Watchdog 24-bit, saturates not wraps.

## Test plan
- Single read: req_rd[2]=1, lba 0x10 → next cycle sd_rd=1, sd_lba=0x10, grant_id=2; sd_busy after 3 cycles → sd_rd=0; 512 strobes appear only on req_strobe[2]; sd_done → one req_done[2] pulse; active=0 two cycles later.
- Fairness: after reset, requesters 0,3,5 hold req_rd continuously, SD model completes each → grant order 0,3,5,0,3.
- Direction: req_rd[1]=req_wr[1]=1 → sd_rd=1, sd_wr=0; req_wr[5] alone → sd_wr=1, sd_rd=0.
- Timeout with TIMEOUT=16: req_rd[4], sd_busy stuck 0 → sd_rd high 16 cycles, req_err[4] pulse, pending req_rd[0] then granted.
- Reset in WAIT_DONE (owner 3) → next cycle all outputs 0; subsequent sd_done does not pulse req_done[3].
- Stray sd_done/strobe while IDLE → no req_done/req_strobe bits, state stays IDLE.

Source files
------------

// File: rtl/sd_request_arbiter_if.sv
// sd_request_arbiter_if: requester-side and SD-controller-side handshake bundle for the arbiter.
interface sd_request_arbiter_if #(parameter int N = 6);
  logic [32*N-1:0] req_lba;
  logic [N-1:0]    req_rd;
  logic [N-1:0]    req_wr;
  logic [N-1:0]    req_busy;
  logic [N-1:0]    req_done;
  logic [N-1:0]    req_strobe;
  logic [N-1:0]    req_err;
  logic [31:0]     sd_lba;
  logic            sd_rd;
  logic            sd_wr;
  logic            sd_busy;
  logic            sd_done;
  logic            sd_rd_byte_strobe;
  logic [2:0]      grant_id;
  logic            active;
  modport master (
    input  req_lba, req_rd, req_wr, sd_busy, sd_done, sd_rd_byte_strobe,
    output req_busy, req_done, req_strobe, req_err, sd_lba, sd_rd, sd_wr, grant_id, active
  );
  modport slave (
    output req_lba, req_rd, req_wr, sd_busy, sd_done, sd_rd_byte_strobe,
    input  req_busy, req_done, req_strobe, req_err, sd_lba, sd_rd, sd_wr, grant_id, active
  );
endinterface

// File: rtl/sd_request_arbiter.sv
// sd_request_arbiter: round-robin sharing of one SD sector controller with a command-accept watchdog.
module sd_request_arbiter #(
  parameter int N       = 6,
  parameter int TIMEOUT = 1000000
) (
  input logic                 clk,
  input logic                 reset,
  sd_request_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RELEASE} state_t;
  localparam logic [23:0] LP_WD_LAST = 24'(TIMEOUT - 1);
  state_t      r_state, w_state_n;
  logic        r_rd, r_wr, w_rd_n, w_wr_n;
  logic [31:0] r_lba, w_lba_n;
  logic [2:0]  r_grant, w_grant_n, r_last, w_last_n, w_pick;
  logic [23:0] r_wd, w_wd_n;
  logic [N-1:0] r_err, w_err_n, w_pend;
  logic        w_active;
  always_comb begin
    w_pend = bus.req_rd | bus.req_wr;
    w_pick = r_last;
    for (int k = N; k >= 1; k--) begin
      int j;
      j = (int'(r_last) + k) % N;
      if (w_pend[j]) w_pick = 3'(j);
    end
  end
  always_comb begin
    w_state_n = r_state;
    w_rd_n    = 1'b0;
    w_wr_n    = 1'b0;
    w_lba_n   = r_lba;
    w_grant_n = r_grant;
    w_last_n  = r_last;
    w_wd_n    = r_wd;
    w_err_n   = '0;
    case (r_state)
      IDLE: if (|w_pend) begin
        w_state_n = ISSUE;
        w_grant_n = w_pick;
        w_lba_n   = bus.req_lba[32*w_pick +: 32];
        w_rd_n    = bus.req_rd[w_pick];
        w_wr_n    = !bus.req_rd[w_pick];
        w_wd_n    = '0;
      end
      ISSUE: if (bus.sd_busy) w_state_n = WAIT_DONE;
      else if (r_wd == LP_WD_LAST) begin
        w_state_n        = RELEASE;
        w_err_n[r_grant] = 1'b1;
      end else begin
        w_rd_n = r_rd;
        w_wr_n = r_wr;
        w_wd_n = (&r_wd) ? r_wd : r_wd + 24'd1;
      end
      WAIT_DONE: w_state_n = bus.sd_done ? RELEASE : WAIT_DONE;
      RELEASE: begin
        w_state_n = IDLE;
        w_last_n  = r_grant;
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_lba   <= '0;
      r_grant <= '0;
      r_last  <= 3'(N - 1);
      r_wd    <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_n;
      r_rd    <= w_rd_n;
      r_wr    <= w_wr_n;
      r_lba   <= w_lba_n;
      r_grant <= w_grant_n;
      r_last  <= w_last_n;
      r_wd    <= w_wd_n;
      r_err   <= w_err_n;
    end
  end
  assign w_active     = (r_state == ISSUE) || (r_state == WAIT_DONE);
  assign bus.sd_rd    = r_rd;
  assign bus.sd_wr    = r_wr;
  assign bus.sd_lba   = r_lba;
  assign bus.grant_id = r_grant;
  assign bus.active   = w_active;
  assign bus.req_err  = r_err;
  for (genvar g = 0; g < N; g++) begin : g_route
    assign bus.req_busy[g]   = bus.sd_busy & w_active & (r_grant == 3'(g));
    assign bus.req_done[g]   = bus.sd_done & (r_state == WAIT_DONE) & (r_grant == 3'(g));
    assign bus.req_strobe[g] = bus.sd_rd_byte_strobe & w_active & (r_grant == 3'(g));
  end
endmodule

// File: tb/tb_sd_request_arbiter.sv
// tb_sd_request_arbiter: directed vectors against hand-computed arbiter behaviour (N=6, TIMEOUT=16).
module tb_sd_request_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  sd_request_arbiter_if #(.N(6)) bus();
  sd_request_arbiter #(.N(6), .TIMEOUT(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask
  task automatic wait_cmd();
    int n = 0;
    while (!(bus.sd_rd | bus.sd_wr) && n < 20) begin
      step();
      n++;
    end
    chk("cmd_wait", 32'(n < 20), 1);
  endtask
  task automatic finish_xfer(input int id);
    bus.sd_busy = 1'b1;
    step();
    bus.sd_done = 1'b1;
    #1;
    chk("xfer_done", 32'(bus.req_done), 32'(1 << id));
    step();
    bus.sd_done = 1'b0;
    bus.sd_busy = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  initial begin
    bus.req_lba = '0;
    bus.req_rd = '0;
    bus.req_wr = '0;
    bus.sd_busy = 1'b0;
    bus.sd_done = 1'b0;
    bus.sd_rd_byte_strobe = 1'b0;
    do_reset();
    chk("rst_sd_rd", 32'(bus.sd_rd), 0);
    chk("rst_sd_wr", 32'(bus.sd_wr), 0);
    chk("rst_lba", bus.sd_lba, 0);
    chk("rst_grant", 32'(bus.grant_id), 0);
    chk("rst_active", 32'(bus.active), 0);
    chk("rst_err", 32'(bus.req_err), 0);
    bus.sd_done = 1'b1;
    bus.sd_rd_byte_strobe = 1'b1;
    #1;
    chk("stray_done", 32'(bus.req_done), 0);
    chk("stray_strobe", 32'(bus.req_strobe), 0);
    step();
    chk("stray_idle", 32'(bus.active), 0);
    bus.sd_done = 1'b0;
    bus.sd_rd_byte_strobe = 1'b0;
    bus.req_lba[32*2 +: 32] = 32'h10;
    bus.req_rd[2] = 1'b1;
    step();
    chk("rd_sd_rd", 32'(bus.sd_rd), 1);
    chk("rd_lba", bus.sd_lba, 32'h10);
    chk("rd_grant", 32'(bus.grant_id), 2);
    chk("rd_active", 32'(bus.active), 1);
    step();
    step();
    chk("rd_hold", 32'(bus.sd_rd), 1);
    bus.sd_busy = 1'b1;
    #1;
    chk("rd_busy_route", 32'(bus.req_busy), 32'h4);
    step();
    chk("rd_cmd_drop", 32'(bus.sd_rd), 0);
    bus.req_rd[2] = 1'b0;
    bus.sd_rd_byte_strobe = 1'b1;
    for (int s = 0; s < 512; s++) begin
      #1;
      chk("rd_strobe", 32'(bus.req_strobe), 32'h4);
      step();
    end
    bus.sd_rd_byte_strobe = 1'b0;
    bus.sd_done = 1'b1;
    #1;
    chk("rd_done", 32'(bus.req_done), 32'h4);
    step();
    bus.sd_done = 1'b0;
    bus.sd_busy = 1'b0;
    #1;
    chk("rd_rel_active", 32'(bus.active), 0);
    chk("rd_rel_done", 32'(bus.req_done), 0);
    step();
    chk("rd_idle_active", 32'(bus.active), 0);
    do_reset();
    bus.req_rd = 6'b101001;
    begin
      int order [5] = '{0, 3, 5, 0, 3};
      foreach (order[q]) begin
        wait_cmd();
        chk("rr_grant", 32'(bus.grant_id), 32'(order[q]));
        finish_xfer(order[q]);
      end
    end
    bus.req_rd = '0;
    bus.req_rd[1] = 1'b1;
    bus.req_wr[1] = 1'b1;
    wait_cmd();
    chk("dir_both_grant", 32'(bus.grant_id), 1);
    chk("dir_both_rd", 32'(bus.sd_rd), 1);
    chk("dir_both_wr", 32'(bus.sd_wr), 0);
    bus.req_rd[1] = 1'b0;
    bus.req_wr[1] = 1'b0;
    finish_xfer(1);
    bus.req_wr[5] = 1'b1;
    wait_cmd();
    chk("dir_wr_grant", 32'(bus.grant_id), 5);
    chk("dir_wr_wr", 32'(bus.sd_wr), 1);
    chk("dir_wr_rd", 32'(bus.sd_rd), 0);
    bus.req_wr[5] = 1'b0;
    finish_xfer(5);
    bus.req_rd[4] = 1'b1;
    wait_cmd();
    chk("to_grant", 32'(bus.grant_id), 4);
    bus.req_rd[0] = 1'b1;
    begin
      int cnt = 1;
      step();
      while (bus.sd_rd && cnt < 40) begin
        cnt++;
        step();
      end
      chk("to_cmd_cycles", 32'(cnt), 16);
    end
    chk("to_err", 32'(bus.req_err), 32'h10);
    bus.req_rd[4] = 1'b0;
    step();
    chk("to_err_clear", 32'(bus.req_err), 0);
    wait_cmd();
    chk("to_next_grant", 32'(bus.grant_id), 0);
    bus.req_rd[0] = 1'b0;
    finish_xfer(0);
    bus.req_lba[32*3 +: 32] = 32'hABCD;
    bus.req_rd[3] = 1'b1;
    wait_cmd();
    chk("rw_grant", 32'(bus.grant_id), 3);
    bus.sd_busy = 1'b1;
    step();
    bus.req_rd[3] = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rw_sd_rd", 32'(bus.sd_rd), 0);
    chk("rw_lba", bus.sd_lba, 0);
    chk("rw_grant0", 32'(bus.grant_id), 0);
    chk("rw_active", 32'(bus.active), 0);
    chk("rw_busy", 32'(bus.req_busy), 0);
    bus.sd_done = 1'b1;
    #1;
    chk("rw_done", 32'(bus.req_done), 0);
    step();
    bus.sd_done = 1'b0;
    bus.sd_busy = 1'b0;
    chk("rw_idle", 32'(bus.active), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
